// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared definitions for the two-master Wishbone arbiter: default bus widths,
// the watchdog counter width, the arbiter state encoding and the round-robin
// arbitration rule used whenever the bus is up for grabs.
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

   localparam int WB_ADR_WIDTH = 64;
   localparam int WB_DAT_WIDTH = 64;
   localparam int WB_SEL_WIDTH = 8;
   localparam int WDOG_WIDTH   = 16;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_GNT0 = 2'd1,
      ARB_GNT1 = 2'd2,
      ARB_TMO  = 2'd3
   } arbState_t;

   // Round-robin pick between the two requesters. On a tie the master that
   // did not hold the most recent grant wins, so neither side can starve.
   function automatic arbState_t arbitrate(input logic cyc0,
                                           input logic cyc1,
                                           input logic lastGrant);
      arbState_t result;
      result = ARB_IDLE;
      if (cyc0 && cyc1) begin
         result = lastGrant ? ARB_GNT0 : ARB_GNT1;
      end else if (cyc0) begin
         result = ARB_GNT0;
      end else if (cyc1) begin
         result = ARB_GNT1;
      end
      return result;
   endfunction

endpackage

// File: rtl/wb_watchdog.sv
// -----------------------------------------------------------------------------
// wb_watchdog
// Counts consecutive stalled bus cycles and flags when a transfer has waited
// TIMEOUT cycles. Kept generic so a per-slave decoder can reuse it later.
//
// Ports:
//   clk_i     in   clock
//   rst_i     in   synchronous active-high reset
//   i_enable  in   the bus is stalled this cycle (strobe up, no ack/err)
//   i_clear   in   restart counting (e.g. the owner of the bus changes)
//   o_fire    out  the stall has lasted TIMEOUT cycles including this one
// -----------------------------------------------------------------------------
module wb_watchdog
   import wb_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic i_enable,
   input  logic i_clear,
   output logic o_fire
);

   // A TIMEOUT of zero switches the watchdog off entirely.
   localparam bit                    WDOG_ON    = (TIMEOUT != 0);
   localparam logic [WDOG_WIDTH-1:0] LAST_COUNT = WDOG_ON ? WDOG_WIDTH'(TIMEOUT - 1) : '0;

   logic [WDOG_WIDTH-1:0] r_count;

   // The count only survives while the stall is unbroken; any cycle that is
   // not a stall (or an explicit clear) starts the wait over from zero.
   always_ff @(posedge clk_i) begin
      if (rst_i || i_clear || !i_enable) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   // Firing needs the stall to still be present on the final cycle, so a
   // termination arriving exactly then wins over the timeout.
   assign o_fire = WDOG_ON && i_enable && (r_count == LAST_COUNT);

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Two-master / one-slave Wishbone arbiter. Master 0 is the CPU, master 1 a
// secondary requester (DMA, debug). Grants round-robin on cyc, holds the grant
// for the whole bus cycle and routes ack/err only to the owner. A watchdog
// ends hung transfers with a one-cycle err so the owner never waits forever.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   m{0,1}_cyc/stb/we/sel/adr/dat_i   master requests
//   m{0,1}_dat_o                 slave read data (broadcast)
//   m{0,1}_ack_o, m{0,1}_err_o   terminations (owner only; err also on timeout)
//   s_cyc/stb/we/sel/adr/dat_o   slave-side bus driven by the owner
//   s_dat_i, s_ack_i, s_err_i    slave read data and terminations
//   tmo_o                        one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int ADR_WIDTH = WB_ADR_WIDTH,
   parameter int DAT_WIDTH = WB_DAT_WIDTH,
   parameter int SEL_WIDTH = WB_SEL_WIDTH,
   parameter int TIMEOUT   = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 m0_cyc_i,
   input  logic                 m0_stb_i,
   input  logic                 m0_we_i,
   input  logic [SEL_WIDTH-1:0] m0_sel_i,
   input  logic [ADR_WIDTH-1:0] m0_adr_i,
   input  logic [DAT_WIDTH-1:0] m0_dat_i,
   output logic [DAT_WIDTH-1:0] m0_dat_o,
   output logic                 m0_ack_o,
   output logic                 m0_err_o,
   input  logic                 m1_cyc_i,
   input  logic                 m1_stb_i,
   input  logic                 m1_we_i,
   input  logic [SEL_WIDTH-1:0] m1_sel_i,
   input  logic [ADR_WIDTH-1:0] m1_adr_i,
   input  logic [DAT_WIDTH-1:0] m1_dat_i,
   output logic [DAT_WIDTH-1:0] m1_dat_o,
   output logic                 m1_ack_o,
   output logic                 m1_err_o,
   output logic                 s_cyc_o,
   output logic                 s_stb_o,
   output logic                 s_we_o,
   output logic [SEL_WIDTH-1:0] s_sel_o,
   output logic [ADR_WIDTH-1:0] s_adr_o,
   output logic [DAT_WIDTH-1:0] s_dat_o,
   input  logic [DAT_WIDTH-1:0] s_dat_i,
   input  logic                 s_ack_i,
   input  logic                 s_err_i,
   output logic                 tmo_o
);

   arbState_t r_state;
   arbState_t w_nextState;
   logic      r_lastGrant;
   logic      w_wdogEnable;
   logic      w_wdogClear;
   logic      w_wdogFire;

   // State register. The last-grant bit starts at 1 so the CPU wins the very
   // first tie, and it only moves when a master newly takes the bus; a timeout
   // leaves it alone so the round-robin order is not disturbed.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ARB_IDLE;
         r_lastGrant <= 1'b1;
      end else begin
         r_state <= w_nextState;
         if (w_nextState == ARB_GNT0 && r_state != ARB_GNT0) begin
            r_lastGrant <= 1'b0;
         end else if (w_nextState == ARB_GNT1 && r_state != ARB_GNT1) begin
            r_lastGrant <= 1'b1;
         end
      end
   end

   // Next-state logic. The owner keeps the bus while its cyc stays high (stb
   // gaps included); the moment it drops cyc we re-arbitrate in the same
   // cycle, so the other master can take over without an idle cycle.
   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         ARB_IDLE: w_nextState = arbitrate(m0_cyc_i, m1_cyc_i, r_lastGrant);
         ARB_GNT0: begin
            if (!m0_cyc_i) begin
               w_nextState = arbitrate(m0_cyc_i, m1_cyc_i, r_lastGrant);
            end else if (w_wdogFire) begin
               w_nextState = ARB_TMO;
            end
         end
         ARB_GNT1: begin
            if (!m1_cyc_i) begin
               w_nextState = arbitrate(m0_cyc_i, m1_cyc_i, r_lastGrant);
            end else if (w_wdogFire) begin
               w_nextState = ARB_TMO;
            end
         end
         ARB_TMO:  w_nextState = ARB_IDLE;
         default:  w_nextState = ARB_IDLE;
      endcase
   end

   // Output logic. The owner's request is passed straight through to the
   // slave and the slave's termination straight back, so ack latency is the
   // slave's own. In the timeout cycle the bus is dropped and the master that
   // held it gets a single forced err.
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_sel_o  = '0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      tmo_o    = 1'b0;
      unique case (r_state)
         ARB_GNT0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i;
         end
         ARB_GNT1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i;
         end
         ARB_TMO: begin
            tmo_o    = 1'b1;
            m0_err_o = !r_lastGrant;
            m1_err_o = r_lastGrant;
         end
         default: begin
         end
      endcase
   end

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   // The watchdog sees a stall whenever the owner is strobing and the slave
   // has not terminated; it restarts on every change of state.
   assign w_wdogEnable = s_stb_o && !s_ack_i && !s_err_i;
   assign w_wdogClear  = (w_nextState != r_state);

   wb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_enable (w_wdogEnable),
      .i_clear  (w_wdogClear),
      .o_fire   (w_wdogFire)
   );

endmodule
